// File: rtl/tone_burst_gen.sv
// tone_burst_gen: multi-channel square-wave burst generator.
//
// Purpose:
//   A start pulse in IDLE latches the per-channel half-periods, the enable
//   mask and the burst duration, then runs a burst (RUN). Each enabled
//   channel with a nonzero half-period toggles every half_period clocks,
//   beginning low. A one-second tick (CLK_FREQ clocks) advances `seconds`.
//   The burst ends when the duration expires or when stop is asserted. It
//   then passes through DONE for one cycle (done pulse) and returns to IDLE.
//   A duration of 0 means the burst runs until stop.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        burst request, sampled in IDLE only
//   stop         abort request, sampled in RUN only
//   half_period  CHANNELS x DIV_W half-periods, channel k at [k*DIV_W +: DIV_W]
//   chan_en      per-channel enable mask
//   duration     burst length in seconds, 0 = continuous
//   signal       registered square-wave outputs
//   busy         high while in RUN
//   done         one-cycle pulse in DONE
//   seconds      whole seconds elapsed in the current or last burst

// One channel: latched configuration plus its own phase counter.
module tone_burst_chan #(
    parameter int DIV_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,         // start accepted: latch config, restart phase
    input  logic             run,          // burst continues past this edge
    input  logic [DIV_W-1:0] half_period,
    input  logic             enable,
    output logic             sig
);
    logic [DIV_W-1:0] hp_q, hp_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             sig_q, sig_d;

    always_comb begin
        hp_d  = hp_q;
        en_d  = en_q;
        cnt_d = cnt_q;
        sig_d = sig_q;
        if (load) begin
            hp_d  = half_period;
            en_d  = enable;
            cnt_d = '0;
            sig_d = 1'b0;
        end else if (run) begin
            // A zero half-period or a disabled channel stays parked low.
            if (en_q && (hp_q != '0)) begin
                if (cnt_q == hp_q - DIV_W'(1)) begin
                    cnt_d = '0;
                    sig_d = ~sig_q;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
        end else begin
            // Leaving RUN (into DONE) or sitting idle: output forced low.
            sig_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hp_q  <= '0;
            en_q  <= 1'b0;
            cnt_q <= '0;
            sig_q <= 1'b0;
        end else begin
            hp_q  <= hp_d;
            en_q  <= en_d;
            cnt_q <= cnt_d;
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
endmodule

module tone_burst_gen #(
    parameter int CLK_FREQ = 27000000,
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 25,
    parameter int DUR_W    = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [CHANNELS*DIV_W-1:0] half_period,
    input  logic [CHANNELS-1:0]       chan_en,
    input  logic [DUR_W-1:0]          duration,
    output logic [CHANNELS-1:0]       signal,
    output logic                      busy,
    output logic                      done,
    output logic [DUR_W-1:0]          seconds
);
    localparam int TICK_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_FREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [DUR_W-1:0]   sec_q, sec_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic               load;
    logic               run;
    logic               wrap;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        sec_d   = sec_q;
        dur_d   = dur_q;
        load    = 1'b0;
        wrap    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                    tick_d  = '0;
                    sec_d   = '0;
                    dur_d   = duration;
                end
            end
            S_RUN: begin
                wrap = (tick_q == TICK_LAST);
                if (wrap) begin
                    tick_d = '0;
                    // Saturate rather than wrap; only reachable in continuous mode.
                    if (sec_q != '1) begin
                        sec_d = sec_q + DUR_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
                // Stop and expiry on the same edge collapse into one DONE.
                if (stop || (wrap && (dur_q != '0) && (sec_q == dur_q - DUR_W'(1)))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Channels advance only while the burst continues past this edge, so
    // the edge into DONE already drives them low.
    assign run = (state_q == S_RUN) && (state_d == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            sec_q   <= '0;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            sec_q   <= sec_d;
            dur_q   <= dur_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        tone_burst_chan #(.DIV_W(DIV_W)) u_chan (
            .clk         (clk),
            .rst         (rst),
            .load        (load),
            .run         (run),
            .half_period (half_period[k*DIV_W +: DIV_W]),
            .enable      (chan_en[k]),
            .sig         (signal[k])
        );
    end

    // Decoded straight from the state flop, so still free of input paths.
    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign seconds = sec_q;
endmodule

// File: doc/tone_burst_gen.md
TONE_BURST_GEN -- requirements
Module: tone_burst_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27000000: input clock frequency in Hz; it sets the one-second tick period.
REQ-002 SHALL have parameter CHANNELS, default 2: number of independent square-wave outputs, legal range 1..8.
REQ-003 SHALL have parameter DIV_W, default 25: width of each per-channel half-period value.
REQ-004 SHALL have parameter DUR_W, default 9: width of the duration and elapsed-seconds values.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: burst request, sampled only in IDLE.
REQ-008 SHALL have port stop, input, 1 bit: abort request, sampled only in RUN.
REQ-009 SHALL have port half_period, input, CHANNELS*DIV_W bits: per-channel half-period in clocks; channel k occupies bits [k*DIV_W +: DIV_W].
REQ-010 SHALL have port chan_en, input, CHANNELS bits: per-channel enable mask.
REQ-011 SHALL have port duration, input, DUR_W bits: burst length in seconds; 0 means run continuously.
REQ-012 SHALL have port signal, output, CHANNELS bits: registered square-wave outputs.
REQ-013 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at burst end.
REQ-015 SHALL have port seconds, output, DUR_W bits: whole seconds elapsed in the current or last burst.

Function
REQ-016 SHALL implement a three-state FSM (IDLE, RUN, DONE) with the transitions IDLE->RUN, RUN->DONE and DONE->IDLE only.
REQ-017 SHALL, in IDLE with start=1, latch half_period, chan_en and duration, clear all counters, clear seconds, and enter RUN, with busy=1 on the next cycle.
REQ-018 SHALL ignore start while in RUN or DONE; there is no queuing and no re-trigger.
REQ-019 SHALL hold signal[k] at 0 for the whole burst when channel k has its latched enable low or its latched half-period equal to 0.
REQ-020 SHALL drive every active channel low on the first RUN cycle and toggle it each time its own counter reaches latched half_period-1, after which that counter wraps to 0, giving a period of exactly 2*half_period clocks.
REQ-021 SHALL make a channel with half_period=1 toggle every clock.
REQ-022 SHALL count the per-channel counters independently; no channel's phase depends on any other channel.
REQ-023 SHALL run a second counter during RUN that wraps at CLK_FREQ-1, incrementing seconds by 1 on each wrap.
REQ-024 SHALL, when duration is nonzero and the second counter wraps while seconds equals duration-1, enter DONE, so that RUN lasts exactly duration*CLK_FREQ cycles.
REQ-025 SHALL, when duration is 0, stay in RUN until stop, with seconds saturating at all-ones instead of wrapping.
REQ-026 SHALL, with stop=1 in RUN, enter DONE on the next cycle, and SHALL generate a single DONE when stop and duration expiry occur in the same cycle.
REQ-027 SHALL, in DONE, drive signal to all-zeros, busy to 0 and done to 1 for exactly one cycle, then return to IDLE.
REQ-028 SHALL hold seconds in IDLE at its final value until the next accepted start.
REQ-029 SHALL keep signal at all-zeros in IDLE.
REQ-030 SHALL have no input-to-output combinational path; all outputs are registered.

Reset
REQ-031 SHALL, with rst=1 on a clock edge, force IDLE, signal=0, busy=0, done=0, seconds=0, and clear all counters and latched configuration.
REQ-032 SHALL give rst priority over start and stop, and SHALL, when rst is asserted mid-burst, abort the burst without emitting a done pulse.

Verification (bench uses CLK_FREQ=20, CHANNELS=2, DIV_W=8, DUR_W=4)
REQ-033 SHALL verify the basic burst: half_period={3,5}, chan_en=2'b11, duration=2, start pulse -> busy high for exactly 40 cycles, signal[0] period 10 clocks, signal[1] period 6 clocks, seconds reaching 2, a single done pulse, then signal=0.
REQ-034 SHALL verify stop: duration=0, start, stop asserted on RUN cycle 57 -> DONE on the next cycle, seconds=2, and seconds holding 2 in IDLE.
REQ-035 SHALL verify channel gating: chan_en=2'b01 with half_period[1]=0 -> signal[1] stays 0 throughout the burst while signal[0] toggles normally.
REQ-036 SHALL verify start is ignored while busy: start re-pulsed at RUN cycle 10 -> burst still ends at cycle 40 with a single done pulse.
REQ-037 SHALL verify reset mid-burst: rst at RUN cycle 15 -> all outputs 0 on the next cycle, no done pulse, and a subsequent start runs a full 40-cycle burst.
REQ-038 SHALL verify the simultaneous event: stop asserted on the final expiry cycle -> exactly one done pulse, and half_period=1 toggles every clock.
